// File: rtl/sap_u_pkg.sv
// -----------------------------------------------------------------------------
// sap_u_pkg
// Shared definitions for the SAP-U control sequencer:
//   - opcode encodings (OP_NOP..OP_HLT)
//   - T-state encoding T0..T4 (t_state_e)
//   - bit indices and width of the packed, active-high control word
// Every control-word bit is active-high inside the design. Active-low outputs
// are inverted only at the sequencer ports.
// -----------------------------------------------------------------------------
package sap_u_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } t_state_e;

  // Control-word bit positions (1 = action requested this step)
  localparam int CW_PC_OUT   = 0;   // PC drives bus
  localparam int CW_MAR_IN   = 1;   // MAR loads from bus
  localparam int CW_RAM_OUT  = 2;   // RAM drives bus
  localparam int CW_IR_IN    = 3;   // IR loads from bus
  localparam int CW_PC_INC   = 4;   // PC increments
  localparam int CW_IR_OUT   = 5;   // IR operand drives bus
  localparam int CW_A_IN     = 6;   // A loads from bus
  localparam int CW_A_OUT    = 7;   // A drives bus
  localparam int CW_B_IN     = 8;   // B loads from bus
  localparam int CW_ALU_OUT  = 9;   // ALU drives bus
  localparam int CW_SUB      = 10;  // ALU computes A-B
  localparam int CW_RAM_WE   = 11;  // RAM write
  localparam int CW_JUMP     = 12;  // PC loads bus[3:0]
  localparam int CW_FLAGS_IN = 13;  // carry/zero flags capture ALU status
  localparam int CW_HALT     = 14;  // enter halted state
  localparam int CW_WIDTH    = 15;

  typedef logic [CW_WIDTH-1:0] cw_t;

endpackage

// File: rtl/sap_u_microcode_rom.sv
// -----------------------------------------------------------------------------
// sap_u_microcode_rom
// Purely combinational microcode table: (opcode, T-state, flags) -> control word.
// Ports:
//   opcode_i  in  4   instruction opcode (IR[7:4])
//   step_i    in  3   current T-state
//   carry_i   in  1   registered carry flag (tied 0 when flags are disabled)
//   zero_i    in  1   registered zero flag  (tied 0 when flags are disabled)
//   cw_o      out 15  active-high control word
// Unknown opcodes fall through to the all-zero word, i.e. they behave as NOP.
// -----------------------------------------------------------------------------
module sap_u_microcode_rom
  import sap_u_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  t_state_e   step_i,
  input  logic       carry_i,
  input  logic       zero_i,
  output cw_t        cw_o
);

  always_comb begin
    cw_o = '0;
    case (step_i)
      T0: begin
        cw_o[CW_PC_OUT] = 1'b1;
        cw_o[CW_MAR_IN] = 1'b1;
      end
      T1: begin
        cw_o[CW_RAM_OUT] = 1'b1;
        cw_o[CW_IR_IN]   = 1'b1;
        cw_o[CW_PC_INC]  = 1'b1;
      end
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw_o[CW_IR_OUT] = 1'b1;
            cw_o[CW_MAR_IN] = 1'b1;
          end
          OP_LDI: begin
            cw_o[CW_IR_OUT] = 1'b1;
            cw_o[CW_A_IN]   = 1'b1;
          end
          OP_JMP: begin
            cw_o[CW_IR_OUT] = 1'b1;
            cw_o[CW_JUMP]   = 1'b1;
          end
          OP_JC: begin
            cw_o[CW_IR_OUT] = carry_i;
            cw_o[CW_JUMP]   = carry_i;
          end
          OP_JZ: begin
            cw_o[CW_IR_OUT] = zero_i;
            cw_o[CW_JUMP]   = zero_i;
          end
          OP_HLT: cw_o[CW_HALT] = 1'b1;
          default: cw_o = '0;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: begin
            cw_o[CW_RAM_OUT] = 1'b1;
            cw_o[CW_A_IN]    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw_o[CW_RAM_OUT] = 1'b1;
            cw_o[CW_B_IN]    = 1'b1;
            cw_o[CW_SUB]     = (opcode_i == OP_SUB);
          end
          OP_STA: begin
            cw_o[CW_A_OUT]  = 1'b1;
            cw_o[CW_RAM_WE] = 1'b1;
          end
          default: cw_o = '0;
        endcase
      end
      T4: begin
        case (opcode_i)
          OP_ADD, OP_SUB: begin
            cw_o[CW_ALU_OUT]  = 1'b1;
            cw_o[CW_A_IN]     = 1'b1;
            cw_o[CW_FLAGS_IN] = 1'b1;
            cw_o[CW_SUB]      = (opcode_i == OP_SUB);
          end
          default: cw_o = '0;
        endcase
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/sap_u_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap_u_control_sequencer
// Instruction register + T0..T4 step counter for the SAP-U CPU. Fetches the
// instruction byte during T1, decodes control lines through
// sap_u_microcode_rom, and stops for good on HLT (until reset).
//
// Configuration macro: SAP_U_FLAGS_EN
//   defined   -> carry/zero flag registers exist, JC/JZ branch on them
//   undefined -> no flags, alu_carry/alu_zero ignored, JC/JZ act as NOP
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   run                           1 = advance, 0 = stall (controls inactive)
//   data_bus_in[7:0]              shared bus, captured into IR at end of T1
//   alu_carry, alu_zero           ALU status, captured at end of ADD/SUB T4
//   ir_bus_out[7:0]               {4'b0, IR[3:0]}
//   ir_bus_enable_n ... jump_n,
//   program_counter_bus_enable_n  datapath controls (_n = active-low)
//   program_counter_enable,
//   alu_subtract                  active-high controls
//   halted                        HLT executed
//   step[2:0]                     current T-state for debug display
//
// Controls depend only on registered state plus the run input, which gates
// them off during a stall so the datapath sees no action in a held step.
// -----------------------------------------------------------------------------
module sap_u_control_sequencer
  import sap_u_pkg::*;
#(
  parameter int STEPS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] data_bus_in,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic [7:0] ir_bus_out,
  output logic       ir_bus_enable_n,
  output logic       reg_a_load_n,
  output logic       reg_a_bus_enable_n,
  output logic       reg_b_load_n,
  output logic       alu_enable_n,
  output logic       alu_subtract,
  output logic       ram_bus_enable_n,
  output logic       ram_write_enable_n,
  output logic       ram_load_mar_reg_n,
  output logic       program_counter_enable,
  output logic       jump_n,
  output logic       program_counter_bus_enable_n,
  output logic       halted,
  output logic [2:0] step
);

  t_state_e   step_q, step_d;
  logic [7:0] ir_q, ir_d;
  logic       halted_q, halted_d;
  logic       flag_carry, flag_zero;
  logic       advance;
  cw_t        cw_rom;
  cw_t        cw;

  assign advance = run & ~halted_q;

  sap_u_microcode_rom u_rom (
    .opcode_i (ir_q[7:4]),
    .step_i   (step_q),
    .carry_i  (flag_carry),
    .zero_i   (flag_zero),
    .cw_o     (cw_rom)
  );

  // Stall or halt masks every action, including IR load and flag capture.
  assign cw = advance ? cw_rom : '0;

  always_comb begin
    step_d   = step_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    if (advance) begin
      step_d = (int'(step_q) == STEPS - 1) ? T0 : t_state_e'(step_q + 3'd1);
      if (cw[CW_IR_IN]) ir_d = data_bus_in;
      if (cw[CW_HALT])  halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= T0;
      ir_q     <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

`ifdef SAP_U_FLAGS_EN
  logic carry_q, carry_d;
  logic zero_q, zero_d;

  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if (cw[CW_FLAGS_IN]) begin
      carry_d = alu_carry;
      zero_d  = alu_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign flag_carry = carry_q;
  assign flag_zero  = zero_q;
`else
  // Without flags, JC/JZ never see a set flag and therefore fall through as NOP.
  logic unused_flag_inputs;
  assign unused_flag_inputs = alu_carry ^ alu_zero ^ cw[CW_FLAGS_IN];
  assign flag_carry = 1'b0;
  assign flag_zero  = 1'b0;
`endif

  assign ir_bus_out                   = {4'b0000, ir_q[3:0]};
  assign ir_bus_enable_n              = ~cw[CW_IR_OUT];
  assign reg_a_load_n                 = ~cw[CW_A_IN];
  assign reg_a_bus_enable_n           = ~cw[CW_A_OUT];
  assign reg_b_load_n                 = ~cw[CW_B_IN];
  assign alu_enable_n                 = ~cw[CW_ALU_OUT];
  assign alu_subtract                 = cw[CW_SUB];
  assign ram_bus_enable_n             = ~cw[CW_RAM_OUT];
  assign ram_write_enable_n           = ~cw[CW_RAM_WE];
  assign ram_load_mar_reg_n           = ~cw[CW_MAR_IN];
  assign program_counter_enable       = cw[CW_PC_INC];
  assign jump_n                       = ~cw[CW_JUMP];
  assign program_counter_bus_enable_n = ~cw[CW_PC_OUT];
  assign halted                       = halted_q;
  assign step                         = step_q;

endmodule

// File: tb/tb_sap_u_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap_u_control_sequencer
// Directed stimulus with hand-derived per-cycle expectations. The driver pushes
// the expected output snapshot of each checked cycle into a queue; an
// independent monitor pops one entry per falling edge and compares it against
// the DUT outputs.
// -----------------------------------------------------------------------------
module tb_sap_u_control_sequencer;

  // Asserted-action mask bits used by the expectation tables
  localparam int M_PCO = 0;   // PC -> bus
  localparam int M_MI  = 1;   // MAR load
  localparam int M_RO  = 2;   // RAM -> bus
  localparam int M_PCE = 3;   // PC increment
  localparam int M_IO  = 4;   // IR -> bus
  localparam int M_AI  = 5;   // A load
  localparam int M_AO  = 6;   // A -> bus
  localparam int M_BI  = 7;   // B load
  localparam int M_EO  = 8;   // ALU -> bus
  localparam int M_SU  = 9;   // subtract
  localparam int M_RW  = 10;  // RAM write
  localparam int M_J   = 11;  // jump

  localparam logic [11:0] K_NONE = 12'h000;
  localparam logic [11:0] K_T0   = (12'h1 << M_PCO) | (12'h1 << M_MI);
  localparam logic [11:0] K_T1   = (12'h1 << M_RO)  | (12'h1 << M_PCE);
  localparam logic [11:0] K_ADDR = (12'h1 << M_IO)  | (12'h1 << M_MI);
  localparam logic [11:0] K_LDA3 = (12'h1 << M_RO)  | (12'h1 << M_AI);
  localparam logic [11:0] K_ADD3 = (12'h1 << M_RO)  | (12'h1 << M_BI);
  localparam logic [11:0] K_ADD4 = (12'h1 << M_EO)  | (12'h1 << M_AI);
  localparam logic [11:0] K_SUB3 = K_ADD3 | (12'h1 << M_SU);
  localparam logic [11:0] K_SUB4 = K_ADD4 | (12'h1 << M_SU);
  localparam logic [11:0] K_STA3 = (12'h1 << M_AO)  | (12'h1 << M_RW);
  localparam logic [11:0] K_LDI2 = (12'h1 << M_IO)  | (12'h1 << M_AI);
  localparam logic [11:0] K_JMP2 = (12'h1 << M_IO)  | (12'h1 << M_J);

`ifdef SAP_U_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [24:0] vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b1;
  logic [7:0] data_bus_in = 8'h00;
  logic       alu_carry = 1'b0;
  logic       alu_zero = 1'b0;
  logic [7:0] ir_bus_out;
  logic       ir_bus_enable_n, reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n;
  logic       alu_enable_n, alu_subtract, ram_bus_enable_n, ram_write_enable_n;
  logic       ram_load_mar_reg_n, program_counter_enable, jump_n;
  logic       program_counter_bus_enable_n, halted;
  logic [2:0] step;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] model_ir = 4'h0;  // operand the bench expects in IR

  always #5 clk = ~clk;

  sap_u_control_sequencer #(.STEPS(5)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .run                          (run),
    .data_bus_in                  (data_bus_in),
    .alu_carry                    (alu_carry),
    .alu_zero                     (alu_zero),
    .ir_bus_out                   (ir_bus_out),
    .ir_bus_enable_n              (ir_bus_enable_n),
    .reg_a_load_n                 (reg_a_load_n),
    .reg_a_bus_enable_n           (reg_a_bus_enable_n),
    .reg_b_load_n                 (reg_b_load_n),
    .alu_enable_n                 (alu_enable_n),
    .alu_subtract                 (alu_subtract),
    .ram_bus_enable_n             (ram_bus_enable_n),
    .ram_write_enable_n           (ram_write_enable_n),
    .ram_load_mar_reg_n           (ram_load_mar_reg_n),
    .program_counter_enable       (program_counter_enable),
    .jump_n                       (jump_n),
    .program_counter_bus_enable_n (program_counter_bus_enable_n),
    .halted                       (halted),
    .step                         (step)
  );

  // Raw pin levels implied by an asserted-action mask
  function automatic logic [24:0] mk(input logic [11:0] m, input logic [3:0] ir_lo,
                                     input logic [2:0] st, input logic h);
    return {4'h0, ir_lo, ~m[M_IO], ~m[M_AI], ~m[M_AO], ~m[M_BI], ~m[M_EO], m[M_SU],
            ~m[M_RO], ~m[M_RW], ~m[M_MI], m[M_PCE], ~m[M_J], ~m[M_PCO], h, st};
  endfunction

  // One clock cycle: drive inputs, optionally queue the expected outputs
  task automatic cyc(input string name, input bit chk, input logic rst, input logic rn,
                     input logic [7:0] bus, input logic c, input logic z,
                     input logic [11:0] m, input logic [3:0] ir_lo,
                     input logic [2:0] st, input logic h);
    exp_t e;
    reset = rst;
    run = rn;
    data_bus_in = bus;
    alu_carry = c;
    alu_zero = z;
    if (chk) begin
      e.name = name;
      e.vec = mk(m, ir_lo, st, h);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Full 5-step instruction with run held high
  task automatic instr(input string name, input logic [7:0] op,
                       input logic [11:0] m2, input logic [11:0] m3, input logic [11:0] m4,
                       input logic c4, input logic z4);
    cyc({name, "_T0"}, 1, 0, 1, 8'h00, 0, 0, K_T0, model_ir, 3'd0, 0);
    cyc({name, "_T1"}, 1, 0, 1, op,    0, 0, K_T1, model_ir, 3'd1, 0);
    model_ir = op[3:0];
    cyc({name, "_T2"}, 1, 0, 1, 8'h00, 0, 0, m2, model_ir, 3'd2, 0);
    cyc({name, "_T3"}, 1, 0, 1, 8'h00, 0, 0, m3, model_ir, 3'd3, 0);
    cyc({name, "_T4"}, 1, 0, 1, 8'h00, c4, z4, m4, model_ir, 3'd4, 0);
  endtask

  // Monitor: one comparison per queued cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [24:0] act;
      e = exp_q.pop_front();
      act = {ir_bus_out, ir_bus_enable_n, reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n,
             alu_enable_n, alu_subtract, ram_bus_enable_n, ram_write_enable_n,
             ram_load_mar_reg_n, program_counter_enable, jump_n,
             program_counter_bus_enable_n, halted, step};
      checks = checks + 1;
      if (act !== e.vec) begin
        errors = errors + 1;
        $display("FAIL %s got=%07h expected=%07h", e.name, act, e.vec);
      end else begin
        $display("ok   %s outputs=%07h", e.name, act);
      end
    end
  end

  initial begin
    int wait_cycles;
    // Reset for two cycles; second cycle already shows T0 decode
    cyc("rst0", 0, 1, 1, 8'h00, 0, 0, K_NONE, 4'h0, 3'd0, 0);
    cyc("rst1", 1, 1, 1, 8'h00, 0, 0, K_T0, 4'h0, 3'd0, 0);
    model_ir = 4'h0;

    instr("LDA_1E", 8'h1E, K_ADDR, K_LDA3, K_NONE, 0, 0);
    instr("SUB_3F", 8'h3F, K_ADDR, K_SUB3, K_SUB4, 0, 0);

    // Carry set by ADD, then JC taken only when flags exist
    instr("ADD_21c", 8'h21, K_ADDR, K_ADD3, K_ADD4, 1, 0);
    instr("JC_73", 8'h73, FLAGS ? K_JMP2 : K_NONE, K_NONE, K_NONE, 0, 0);
    // Carry cleared by ADD: JC not taken
    instr("ADD_22", 8'h22, K_ADDR, K_ADD3, K_ADD4, 0, 0);
    instr("JC_74", 8'h74, K_NONE, K_NONE, K_NONE, 0, 0);
    // Zero set by ADD: JZ taken only when flags exist; LDA must not disturb flags
    instr("ADD_23z", 8'h23, K_ADDR, K_ADD3, K_ADD4, 0, 1);
    instr("LDA_12", 8'h12, K_ADDR, K_LDA3, K_NONE, 0, 0);
    instr("JZ_85", 8'h85, FLAGS ? K_JMP2 : K_NONE, K_NONE, K_NONE, 0, 0);

    instr("STA_4C", 8'h4C, K_ADDR, K_STA3, K_NONE, 0, 0);
    instr("LDI_57", 8'h57, K_LDI2, K_NONE, K_NONE, 0, 0);
    instr("JMP_61", 8'h61, K_JMP2, K_NONE, K_NONE, 0, 0);
    instr("NOP_00", 8'h00, K_NONE, K_NONE, K_NONE, 0, 0);
    instr("UNDEF_9A", 8'h9A, K_NONE, K_NONE, K_NONE, 0, 0);

    // Stall at T3 for three cycles, then resume at T3
    cyc("stl_T0", 1, 0, 1, 8'h00, 0, 0, K_T0, model_ir, 3'd0, 0);
    cyc("stl_T1", 1, 0, 1, 8'h19, 0, 0, K_T1, model_ir, 3'd1, 0);
    model_ir = 4'h9;
    cyc("stl_T2", 1, 0, 1, 8'h00, 0, 0, K_ADDR, model_ir, 3'd2, 0);
    for (int i = 0; i < 3; i++)
      cyc("stl_hold", 1, 0, 0, 8'h55, 0, 0, K_NONE, model_ir, 3'd3, 0);
    cyc("stl_T3", 1, 0, 1, 8'h00, 0, 0, K_LDA3, model_ir, 3'd3, 0);
    cyc("stl_T4", 1, 0, 1, 8'h00, 0, 0, K_NONE, model_ir, 3'd4, 0);

    // Reset asserted during T2 aborts the instruction
    cyc("ab_T0", 1, 0, 1, 8'h00, 0, 0, K_T0, model_ir, 3'd0, 0);
    cyc("ab_T1", 1, 0, 1, 8'h5A, 0, 0, K_T1, model_ir, 3'd1, 0);
    model_ir = 4'hA;
    cyc("ab_T2rst", 1, 1, 1, 8'h00, 0, 0, K_LDI2, model_ir, 3'd2, 0);
    model_ir = 4'h0;
    cyc("ab_T0", 1, 0, 1, 8'h00, 0, 0, K_T0, model_ir, 3'd0, 0);
    cyc("ab_T1", 1, 0, 1, 8'h5A, 0, 0, K_T1, model_ir, 3'd1, 0);
    model_ir = 4'hA;
    cyc("ab_T2", 1, 0, 1, 8'h00, 0, 0, K_LDI2, model_ir, 3'd2, 0);
    cyc("ab_T3", 1, 0, 1, 8'h00, 0, 0, K_NONE, model_ir, 3'd3, 0);
    cyc("ab_T4", 1, 0, 1, 8'h00, 0, 0, K_NONE, model_ir, 3'd4, 0);

    // HLT: halted rises at the edge ending T2, step frozen at 3
    cyc("hlt_T0", 1, 0, 1, 8'h00, 0, 0, K_T0, model_ir, 3'd0, 0);
    cyc("hlt_T1", 1, 0, 1, 8'hF0, 0, 0, K_T1, model_ir, 3'd1, 0);
    model_ir = 4'h0;
    cyc("hlt_T2", 1, 0, 1, 8'h00, 0, 0, K_NONE, model_ir, 3'd2, 0);
    for (int i = 0; i < 10; i++)
      cyc("hlt_hold", 1, 0, 1, 8'hAB, 1, 1, K_NONE, model_ir, 3'd3, 1);
    cyc("hlt_rst", 1, 1, 1, 8'h00, 0, 0, K_NONE, model_ir, 3'd3, 1);
    cyc("post_T0", 1, 0, 1, 8'h00, 0, 0, K_T0, 4'h0, 3'd0, 0);
    cyc("post_T1", 1, 0, 1, 8'h12, 0, 0, K_T1, 4'h0, 3'd1, 0);
    cyc("post_T2", 1, 0, 1, 8'h00, 0, 0, K_ADDR, 4'h2, 3'd2, 0);

    // Let the monitor drain, bounded
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_u_control_sequencer.md
# sap_u_control_sequencer

Instruction register plus microcode sequencer for the SAP-U processor. It fetches each instruction byte from the shared data bus and steps through five timing states, T0–T4. In each state it drives the active-low control lines of registers A/B, the ALU, RAM/MAR and the program counter, which sits directly upstream of the datapath. It also drives the instruction operand onto the bus and halts on HLT.

## Interface
Parameters:
- STEPS, 5, microcode steps per instruction (T0..T4). Only 5 is supported.

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = advance; 0 = stall (state held, all controls inactive).
- data_bus_in  in  8  shared bus value; captured into IR during T1.
- alu_carry  in  1  ALU carry-out (used only with SAP_U_FLAGS_EN).
- alu_zero  in  1  ALU result == 0 (used only with SAP_U_FLAGS_EN).
- ir_bus_out  out  8  {4'b0000, ir[3:0]}, the operand.
- ir_bus_enable_n  out  1  IR drives bus (active-low).
- reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n  out  1 each  register A/B controls (active-low).
- alu_enable_n  out  1  ALU drives bus (active-low).
- alu_subtract  out  1  1 = A−B.
- ram_bus_enable_n, ram_write_enable_n, ram_load_mar_reg_n  out  1 each  RAM/MAR controls (active-low).
- program_counter_enable  out  1  PC increments at next edge.
- jump_n  out  1  PC loads bus[3:0] (active-low).
- program_counter_bus_enable_n  out  1  PC drives bus (active-low).
- halted  out  1  HLT executed.
- step  out  3  current T-state, 0..4, for debug display.

## Operation
Opcode is ir[7:4]; operand is ir[3:0].

Instruction set:
- 0x0 NOP.
- 0x1 LDA.
- 0x2 ADD.
- 0x3 SUB.
- 0x4 STA.
- 0x5 LDI.
- 0x6 JMP.
- 0x7 JC.
- 0x8 JZ.
- 0xF HLT.
- Any other opcode executes as NOP.

Microcode (signals listed are asserted; all others inactive):
- T0: program_counter_bus_enable_n, ram_load_mar_reg_n.
- T1: ram_bus_enable_n, IR load, program_counter_enable.
- LDA: T2 ir_bus_enable_n + ram_load_mar_reg_n; T3 ram_bus_enable_n + reg_a_load_n.
- ADD/SUB: T2 as LDA; T3 ram_bus_enable_n + reg_b_load_n; T4 alu_enable_n + reg_a_load_n + flags load. For SUB, alu_subtract is also high in T3 and T4.
- STA: T2 as LDA; T3 reg_a_bus_enable_n + ram_write_enable_n.
- LDI: T2 ir_bus_enable_n + reg_a_load_n.
- JMP: T2 ir_bus_enable_n + jump_n.
- JC/JZ: as JMP only when the respective flag is set; otherwise NOP.
- HLT: at the T2 edge, halted ← 1.

Step sequencing and stall/halt:
- The step counter always runs 0→1→2→3→4→0; there is no early termination.
- While halted=1 or run=0, the step counter and IR hold and every control output is inactive.
- halted clears only on reset.

Output decode and bus contention:
- Control outputs are decoded combinationally from registered state only: step, IR, flags, halted.
- No combinational path exists from data_bus_in or alu_* to any output.
- At most one bus-enable is asserted per step.

## Timing
Reset values:
- step=0, IR=0x00, flags=0, halted=0.
- Outputs in reset show T0 decode: program_counter_bus_enable_n=0, ram_load_mar_reg_n=0, all else inactive.
- Reset asserted mid-instruction aborts it; the next cycle after reset is T0.

Cycle-level timing:
- Each instruction takes exactly 5 enabled cycles.
- IR captures data_bus_in at the rising edge that ends T1. Controls for T2 reflect the new IR one cycle later.
- Flags (carry, zero) capture alu_* at the edge ending T4 of ADD/SUB only.
- Simultaneous reset and run: reset wins.
- Stall on run=0 is entered and left on clock-edge boundaries; no step is skipped or repeated.

## Configuration
- SAP_U_FLAGS_EN defined: the carry/zero flag registers exist and JC/JZ branch as specified.
- Undefined: there are no flag registers, alu_carry/alu_zero are ignored, and opcodes 0x7/0x8 execute as NOP.

## Structure
- Package sap_u_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - T-state constants T0..T4;
  - control-word bit indices and the width of the packed control word.
- Sub-module sap_u_microcode_rom: purely combinational (opcode, step, carry, zero) → control word.
- The sequencer holds the step counter, IR, flags and halted, and unpacks the control word onto the ports.

## Test plan
- Reset: hold reset 2 cycles → step=0, halted=0, ir_bus_out=0x00, program_counter_bus_enable_n=0, ram_load_mar_reg_n=0, all else 1/0 inactive.
- LDA fetch: bus=0x1E during T1 → T2 ir_bus_out=0x0E with ir_bus_enable_n=0 and ram_load_mar_reg_n=0; T3 ram_bus_enable_n=0 and reg_a_load_n=0; back at T0 on cycle 6.
- SUB: bus=0x3F → alu_subtract=1 in T3–T4; T4 alu_enable_n=0 and reg_a_load_n=0; no other bus-enable active.
- JC (SAP_U_FLAGS_EN): ADD with alu_carry=1 at T4, then bus=0x73 → T2 jump_n=0, ir_bus_out=0x03. With carry=0 → jump_n stays 1. With macro undefined → jump_n stays 1 regardless.
- HLT: bus=0xF0 → halted=1 after T2 edge; 10 further cycles have step frozen and all controls inactive; reset → halted=0, step=0.
- Stall/abort: run=0 at T3 for 3 cycles → step holds at 3 with controls inactive, then resumes at T3. Reset at T2 → next cycle T0.
